neuron_mac_n: RTL and testbench
===============================

// Module: neuron_mac_n
// PURPOSE
//  Parametrised N-input fixed-point neuron for the forward path. Single shared MAC,
//  one product per cycle; output activation selectable per transaction: sigmoid, ReLU, linear.
//  Valid/ready on both input and output, so layer controllers can chain neurons
//  and stall them. Sits between the layer weight/bias store and the next layer.
// PARAMETERS
//  DATA_W      16   signed operand/result width
//  FRAC_W      8    fractional bits (Q(DATA_W-FRAC_W).FRAC_W)
//  NUM_INPUTS  2    number of input/weight pairs; must be >= 1
//  ROM_IN_W    8    Sig_ROM address width; address = sat_sum[DATA_W-1 -: ROM_IN_W]
// PORTS
//  clk        in   1                    clock, rising edge
//  rst        in   1                    asynchronous reset, active-high
//  in_valid   in   1                    operand bundle valid
//  in_ready   out  1                    block can accept a bundle
//  in_data    in   NUM_INPUTS*DATA_W    packed signed inputs; x[i] at [i*DATA_W +: DATA_W]
//  in_weight  in   NUM_INPUTS*DATA_W    packed signed weights, same packing as in_data
//  in_bias    in   DATA_W               signed bias, Qx.FRAC_W
//  act_mode   in   2                    0=linear, 1=ReLU, 2=sigmoid, 3=reserved (treated as linear)
//  out_data   out  DATA_W               activation result
//  out_sat    out  1                    pre-activation sum clipped during saturation
//  out_valid  out  1                    result valid; held until out_ready
//  out_ready  in   1                    downstream accepts result
// BEHAVIOUR
//  - Reset values: in_ready=0 during rst, then 1. out_data=0, out_sat=0, out_valid=0.
//    Accumulator, index and latched operands are cleared. FSM returns to IDLE.
//  - FSM: IDLE -> MAC -> SCALE -> ACT -> ROMWAIT -> OUT -> IDLE.
//  - IDLE: in_ready=1. When in_valid&&in_ready, latch data, weights, bias and act_mode,
//    clear acc, set idx=0, then go to MAC. in_ready=0 in every other state.
//  - MAC: acc += x[idx]*w[idx] (signed, full precision) each cycle. idx runs 0..NUM_INPUTS-1.
//    After the last product, go to SCALE.
//  - Accumulator width ACC_W = 2*DATA_W + $clog2(NUM_INPUTS)+1. No overflow possible.
//  - SCALE: s = ((acc + 2^(FRAC_W-1)) >>> FRAC_W) + sign_ext(bias). Shift is arithmetic,
//    rounding is half-up. Saturate s to signed DATA_W range (0x7FFF / 0x8000 at 16 bits).
//    Record sat flag. Register the result as sat_sum.
//  - ACT: compute mode result.
//      linear = sat_sum
//      ReLU   = sat_sum<0 ? 0 : sat_sum
//      sigmoid = address Sig_ROM with the top ROM_IN_W bits of sat_sum
//  - ROMWAIT: one cycle in all modes, so latency is the same for every mode. Capture the
//    selected result into out_data and out_sat, assert out_valid, go to OUT.
//  - Fixed latency: out_valid rises NUM_INPUTS+4 cycles after the accept edge.
//  - OUT: out_valid=1, out_data and out_sat stable. On out_ready, drop out_valid next cycle
//    and go to IDLE. No bubble-free overlap: the next accept happens at earliest the cycle
//    after the handshake.
//  - in_valid during a busy state is ignored; the bundle is not consumed. Operand changes
//    after the accept have no effect.
//  - rst at any point aborts the transaction. No partial result is ever presented.
//  - act_mode=3 behaves as linear.
// STRUCTURE
//  - neuron_pkg holds:
//      ACT_LINEAR/ACT_RELU/ACT_SIGMOID/ACT_RSVD constants
//      FSM state encoding (3-bit localparams)
//      default FRAC_W
//  - Sub-module: the existing Sig_ROM (inWidth=ROM_IN_W, dataWidth=DATA_W), one-cycle
//    registered read. No other sub-module: MAC, scaling and FSM live in this file.
//  - One multiplier, with the operand mux indexed by idx.
// TESTING  (DATA_W=16, FRAC_W=8, NUM_INPUTS=2 unless noted)
//  1 Linear: x={0x0100,0x0100}, w={0x0200,0x0200}, b=0xFF00
//    -> out_data=0x0300, out_sat=0, out_valid at accept+6
//  2 ReLU: same x,w, b=0xF800 -> out_data=0x0000. Repeat with b=0x0000 -> 0x0400.
//  3 Saturation: x={0x7FFF,0x7FFF}, w={0x7FFF,0x7FFF}, linear -> 0x7FFF, out_sat=1.
//    Negate w -> 0x8000, out_sat=1.
//  4 Sigmoid: x=0, w=0, b=0x0000 -> out_data == Sig_ROM[0x00].
//    b=0x0500 -> out_data == Sig_ROM[0x05].
//  5 Backpressure: hold out_ready=0 for 5 cycles -> out_valid and out_data stable,
//    in_ready=0, in_valid pulses ignored. Release -> one handshake, in_ready=1 next cycle.
//  6 Reset: assert rst in the middle of MAC -> all outputs 0 the same cycle.
//    Next transaction after release produces a correct result.
//    Rerun test 1 with NUM_INPUTS=8 and check latency is 12.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared constants for the fixed-point neuron: activation codes, FSM states and
// the default fractional width used by the neuron and its sigmoid table.
package neuron_pkg;

  localparam logic [1:0] ACT_LINEAR  = 2'd0;
  localparam logic [1:0] ACT_RELU    = 2'd1;
  localparam logic [1:0] ACT_SIGMOID = 2'd2;
  localparam logic [1:0] ACT_RSVD    = 2'd3;

  localparam int DEF_FRAC_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MAC     = 3'd1,
    ST_SCALE   = 3'd2,
    ST_ACT     = 3'd3,
    ST_ROMWAIT = 3'd4,
    ST_OUT     = 3'd5
  } state_t;

endpackage

// File: rtl/Sig_ROM.sv
// Sigmoid lookup with one-cycle registered read. The address is the signed integer
// part of the pre-activation sum; output is Q.DEF_FRAC_W (piecewise-linear sigmoid).
module Sig_ROM
  import neuron_pkg::*;
#(
  parameter int inWidth   = 8,
  parameter int dataWidth = 16
) (
  input  logic                 clk,
  input  logic [inWidth-1:0]   i_addr,
  output logic [dataWidth-1:0] o_data
);

  localparam int ONE = 1 << DEF_FRAC_W;

  logic [dataWidth-1:0] r_data;

  // Segments 0.25x+0.5, 0.125x+0.625, 0.03125x+0.84375, 1; mirrored for x<0.
  function automatic logic [dataWidth-1:0] sig_val(input logic signed [inWidth-1:0] a);
    int m;
    int y;
    m = (a < 0) ? -int'(a) : int'(a);
    if (m >= 5)      y = ONE;
    else if (m >= 3) y = (ONE / 32) * m + (27 * ONE) / 32;
    else if (m >= 1) y = (ONE / 8) * m + (5 * ONE) / 8;
    else             y = ONE / 2;
    if (a < 0) y = ONE - y;
    return dataWidth'(y);
  endfunction

  always_ff @(posedge clk) begin
    r_data <= sig_val($signed(i_addr));
  end

  assign o_data = r_data;

endmodule

// File: rtl/neuron_mac_n.sv
// N-input fixed-point neuron: one shared multiplier, rounding/saturating rescale,
// selectable linear/ReLU/sigmoid activation, valid/ready on both sides.
module neuron_mac_n
  import neuron_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FRAC_W     = DEF_FRAC_W,
  parameter int NUM_INPUTS = 2,
  parameter int ROM_IN_W   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_INPUTS*DATA_W-1:0]   in_data,
  input  logic [NUM_INPUTS*DATA_W-1:0]   in_weight,
  input  logic [DATA_W-1:0]              in_bias,
  input  logic [1:0]                     act_mode,
  output logic [DATA_W-1:0]              out_data,
  output logic                           out_sat,
  output logic                           out_valid,
  input  logic                           out_ready
);

  localparam int ACC_W = 2*DATA_W + $clog2(NUM_INPUTS) + 1;
  localparam int SUM_W = ACC_W + 1;
  localparam int IDX_W = $clog2(NUM_INPUTS + 1);
  localparam int DEPTH = 2**IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS);

  state_t                    r_state;
  logic                      r_in_ready;
  logic [1:0]                r_mode;
  logic signed [DATA_W-1:0]  r_x [DEPTH];
  logic signed [DATA_W-1:0]  r_w [DEPTH];
  logic signed [DATA_W-1:0]  r_bias;
  logic [IDX_W-1:0]          r_idx;
  logic signed [2*DATA_W-1:0] r_prod;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [DATA_W-1:0]  r_sat_sum;
  logic signed [DATA_W-1:0]  r_act_res;
  logic                      r_sat;
  logic [DATA_W-1:0]         r_out_data;
  logic                      r_out_sat;
  logic                      r_out_valid;

  logic signed [DATA_W-1:0]   w_in_x [DEPTH];
  logic signed [DATA_W-1:0]   w_in_w [DEPTH];
  logic signed [2*DATA_W-1:0] w_mx, w_mw, w_prod;
  logic signed [SUM_W-1:0]    w_rnd, w_s;
  logic                       w_ovf;
  logic [DATA_W-1:0]          w_sat_val, w_sum_sat;
  logic [DATA_W-1:0]          w_rom_data;

  // Operand slots beyond NUM_INPUTS stay zero, so the drain cycle multiplies 0*0.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_unpack
      if (gi < NUM_INPUTS) begin : g_used
        assign w_in_x[gi] = in_data[gi*DATA_W +: DATA_W];
        assign w_in_w[gi] = in_weight[gi*DATA_W +: DATA_W];
      end else begin : g_pad
        assign w_in_x[gi] = '0;
        assign w_in_w[gi] = '0;
      end
    end
  endgenerate

  assign w_mx   = (2*DATA_W)'(r_x[r_idx]);
  assign w_mw   = (2*DATA_W)'(r_w[r_idx]);
  assign w_prod = w_mx * w_mw;

  // Half-up rounding, arithmetic shift, then bias in the same Q format.
  assign w_rnd     = SUM_W'(r_acc) + (SUM_W'(1) <<< (FRAC_W - 1));
  assign w_s       = (w_rnd >>> FRAC_W) + SUM_W'(r_bias);
  assign w_ovf     = ~((&w_s[SUM_W-1:DATA_W-1]) | ~(|w_s[SUM_W-1:DATA_W-1]));
  assign w_sat_val = w_s[SUM_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
  assign w_sum_sat = w_ovf ? w_sat_val : w_s[DATA_W-1:0];

  Sig_ROM #(
    .inWidth   (ROM_IN_W),
    .dataWidth (DATA_W)
  ) u_sig_rom (
    .clk    (clk),
    .i_addr (r_sat_sum[DATA_W-1 -: ROM_IN_W]),
    .o_data (w_rom_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b0;
      r_mode      <= ACT_LINEAR;
      r_bias      <= '0;
      r_idx       <= '0;
      r_prod      <= '0;
      r_acc       <= '0;
      r_sat_sum   <= '0;
      r_act_res   <= '0;
      r_sat       <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
      r_out_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_x[i] <= '0;
        r_w[i] <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_in_ready <= 1'b1;
          if (in_valid && r_in_ready) begin
            r_x        <= w_in_x;
            r_w        <= w_in_w;
            r_bias     <= in_bias;
            r_mode     <= act_mode;
            r_acc      <= '0;
            r_prod     <= '0;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_MAC;
          end
        end
        // Product is registered; the cycle at idx==NUM_INPUTS drains the last one.
        ST_MAC: begin
          r_prod <= w_prod;
          r_acc  <= r_acc + ACC_W'(r_prod);
          if (r_idx == LAST_IDX) r_state <= ST_SCALE;
          else                   r_idx   <= r_idx + 1'b1;
        end
        ST_SCALE: begin
          r_sat_sum <= w_sum_sat;
          r_sat     <= w_ovf;
          r_state   <= ST_ACT;
        end
        ST_ACT: begin
          case (r_mode)
            ACT_RELU:                          r_act_res <= r_sat_sum[DATA_W-1] ? '0 : r_sat_sum;
            ACT_LINEAR, ACT_SIGMOID, ACT_RSVD: r_act_res <= r_sat_sum;
            default:                           r_act_res <= r_sat_sum;
          endcase
          r_state <= ST_ROMWAIT;
        end
        ST_ROMWAIT: begin
          r_out_data  <= (r_mode == ACT_SIGMOID) ? w_rom_data : r_act_res;
          r_out_sat   <= r_sat;
          r_out_valid <= 1'b1;
          r_state     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_in_ready <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_neuron_mac_n.sv
// Self-checking bench for neuron_mac_n: directed vector table, backpressure,
// mid-transaction reset, randomized traffic against a reference model, N=8 latency.
module tb_neuron_mac_n;

  localparam int DW = 16;
  localparam int N  = 2;
  localparam int N8 = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            in_valid, in_ready, out_sat, out_valid, out_ready;
  logic [N*DW-1:0] in_data, in_weight;
  logic [DW-1:0]   in_bias, out_data;
  logic [1:0]      act_mode;

  logic             in_valid8, in_ready8, out_sat8, out_valid8, out_ready8;
  logic [N8*DW-1:0] in_data8, in_weight8;
  logic [DW-1:0]    in_bias8, out_data8;
  logic [1:0]       act_mode8;

  neuron_mac_n #(.DATA_W(DW), .FRAC_W(8), .NUM_INPUTS(N), .ROM_IN_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_weight(in_weight), .in_bias(in_bias), .act_mode(act_mode),
    .out_data(out_data), .out_sat(out_sat), .out_valid(out_valid), .out_ready(out_ready)
  );

  neuron_mac_n #(.DATA_W(DW), .FRAC_W(8), .NUM_INPUTS(N8), .ROM_IN_W(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_data(in_data8), .in_weight(in_weight8), .in_bias(in_bias8), .act_mode(act_mode8),
    .out_data(out_data8), .out_sat(out_sat8), .out_valid(out_valid8), .out_ready(out_ready8)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Piecewise-linear sigmoid of an integer argument, returned in Q8.8.
  function automatic int sig_ref(input int a);
    real ax, y;
    ax = (a < 0) ? -a : a;
    if (ax >= 5.0)        y = 1.0;
    else if (ax >= 2.375) y = 0.03125 * ax + 0.84375;
    else if (ax >= 1.0)   y = 0.125 * ax + 0.625;
    else                  y = 0.25 * ax + 0.5;
    if (a < 0) y = 1.0 - y;
    return $rtoi(y * 256.0 + 0.5);
  endfunction

  // Dot product, round half-up to Q8.8, add bias, clamp, activate.
  function automatic void model(input logic [N*DW-1:0] xd, input logic [N*DW-1:0] wd,
                                input logic [DW-1:0] b, input logic [1:0] m,
                                output logic [DW-1:0] d, output logic s);
    longint acc = 0;
    longint v;
    for (int i = 0; i < N; i++)
      acc += longint'($signed(xd[i*DW +: DW])) * longint'($signed(wd[i*DW +: DW]));
    v = longint'($floor((real'(acc) + 128.0) / 256.0)) + longint'($signed(b));
    s = (v > 32767) || (v < -32768);
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    case (m)
      2'd1:    d = (v < 0) ? 16'h0000 : 16'(v);
      2'd2:    d = 16'(sig_ref(int'($floor(real'(v) / 256.0))));
      default: d = 16'(v);
    endcase
  endfunction

  function automatic logic [DW-1:0] rnd16(input int lo, input int hi);
    logic signed [DW-1:0] r;
    r = DW'($urandom);
    return DW'(r >>> $urandom_range(lo, hi));
  endfunction

  // One transaction on the N=2 instance; optional output hold with ignored in_valid pulses.
  task automatic txn(input logic [N*DW-1:0] xd, input logic [N*DW-1:0] wd,
                     input logic [DW-1:0] b, input logic [1:0] m, input int hold,
                     output logic [DW-1:0] d, output logic s, output int lat);
    int t;
    @(negedge clk);
    t = 0;
    while (in_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL in_ready_wait: got %0b expected 1", in_ready);
    end
    in_valid = 1'b1; in_data = xd; in_weight = wd; in_bias = b; act_mode = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data = {N{rnd16(0, 0)}}; in_weight = {N{rnd16(0, 0)}};
    in_bias = rnd16(0, 0); act_mode = 2'($urandom);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    d = out_data;
    s = out_sat;
    for (int k = 0; k < hold; k++) begin
      in_valid = ~k[0];
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, d);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hs_valid_drop", out_valid, 0);
    check("hs_in_ready", in_ready, 1);
  endtask

  typedef struct {
    logic [N*DW-1:0] x;
    logic [N*DW-1:0] w;
    logic [DW-1:0]   b;
    logic [1:0]      m;
    logic [DW-1:0]   d;
    logic            s;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] d, ed;
    logic s, es;
    int lat;
    logic [N*DW-1:0] rx, rw;
    logic [DW-1:0] rb;
    logic [1:0] rm;

    tbl[0] = '{32'h0100_0100, 32'h0200_0200, 16'hFF00, 2'd0, 16'h0300, 1'b0};
    tbl[1] = '{32'h0100_0100, 32'h0200_0200, 16'hF800, 2'd1, 16'h0000, 1'b0};
    tbl[2] = '{32'h0100_0100, 32'h0200_0200, 16'h0000, 2'd1, 16'h0400, 1'b0};
    tbl[3] = '{32'h7FFF_7FFF, 32'h7FFF_7FFF, 16'h0000, 2'd0, 16'h7FFF, 1'b1};
    tbl[4] = '{32'h7FFF_7FFF, 32'h8001_8001, 16'h0000, 2'd0, 16'h8000, 1'b1};
    tbl[5] = '{32'h0000_0000, 32'h0000_0000, 16'h0000, 2'd2, 16'h0080, 1'b0};
    tbl[6] = '{32'h0000_0000, 32'h0000_0000, 16'h0500, 2'd2, 16'h0100, 1'b0};
    tbl[7] = '{32'h0100_0100, 32'h0200_0200, 16'hFF00, 2'd3, 16'h0300, 1'b0};

    rst = 1'b1;
    in_valid = 0; in_data = '0; in_weight = '0; in_bias = '0; act_mode = '0; out_ready = 0;
    in_valid8 = 0; in_data8 = '0; in_weight8 = '0; in_bias8 = '0; act_mode8 = '0; out_ready8 = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_data", out_data, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", in_ready, 1);

    for (int i = 0; i < 8; i++) begin
      txn(tbl[i].x, tbl[i].w, tbl[i].b, tbl[i].m, (i == 0) ? 5 : 0, d, s, lat);
      $display("vec %0d: mode %0d data %04h sat %0b latency %0d", i, tbl[i].m, d, s, lat);
      check("vec_data", d, tbl[i].d);
      check("vec_sat", s, tbl[i].s);
      check("vec_latency", lat, 6);
      if (i == 0) begin
        repeat (8) begin
          @(posedge clk); #1;
          check("no_phantom_txn", out_valid, 0);
        end
      end
    end

    for (int i = 0; i < 40; i++) begin
      rx = {rnd16(3, 12), rnd16(3, 12)};
      rw = {rnd16(3, 12), rnd16(3, 12)};
      rb = rnd16(2, 10);
      rm = 2'($urandom_range(0, 3));
      model(rx, rw, rb, rm, ed, es);
      txn(rx, rw, rb, rm, 0, d, s, lat);
      $display("rnd %0d: mode %0d data %04h sat %0b exp %04h/%0b", i, rm, d, s, ed, es);
      check("rnd_data", d, ed);
      check("rnd_sat", s, es);
      check("rnd_latency", lat, 6);
    end

    // Leave a nonzero saturated result on the outputs, then abort a transaction in MAC.
    txn(tbl[3].x, tbl[3].w, tbl[3].b, tbl[3].m, 0, d, s, lat);
    @(negedge clk);
    in_valid = 1'b1; in_data = tbl[0].x; in_weight = tbl[0].w; in_bias = tbl[0].b; act_mode = 2'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    $display("reset mid-MAC: data %04h sat %0b valid %0b ready %0b", out_data, out_sat, out_valid, in_ready);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_sat", out_sat, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    @(negedge clk) rst = 1'b0;
    repeat (2) @(posedge clk);
    txn(tbl[0].x, tbl[0].w, tbl[0].b, tbl[0].m, 0, d, s, lat);
    $display("after reset: data %04h sat %0b latency %0d", d, s, lat);
    check("after_rst_data", d, 16'h0300);
    check("after_rst_latency", lat, 6);

    @(negedge clk);
    in_valid8 = 1'b1; in_data8 = {N8{16'h0100}}; in_weight8 = {N8{16'h0200}};
    in_bias8 = 16'hFF00; act_mode8 = 2'd0;
    if (in_ready8 !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL n8_in_ready: got %0b expected 1", in_ready8);
    end
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 0;
    while (out_valid8 !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("n8: data %04h sat %0b latency %0d", out_data8, out_sat8, lat);
    check("n8_data", out_data8, 16'h0F00);
    check("n8_sat", out_sat8, 0);
    check("n8_latency", lat, 12);
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    check("n8_hs_valid_drop", out_valid8, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
